// File: rtl/fractal_sync_rx.sv
// fractal_sync_rx: queues East-North and West-South sync requests per port, then
// merges matching heads or round-robin arbitrates them onto one downstream channel.
module fractal_sync_rx #(
  parameter int unsigned SRC_IN_W   = 4,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          COMB_IN    = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_sync_i,
  input  logic [SRC_IN_W-1:0] en_src_i,
  input  logic [ID_W-1:0]     en_id_i,
  input  logic                ws_sync_i,
  input  logic [SRC_IN_W-1:0] ws_src_i,
  input  logic [ID_W-1:0]     ws_id_i,
  output logic                en_error_overflow_o,
  output logic                ws_error_overflow_o,
  output logic                req_valid_o,
  output logic [SRC_IN_W+1:0] req_src_o,
  output logic [ID_W-1:0]     req_id_o,
  input  logic                req_ready_i
);

  localparam int unsigned ENTRY_W = SRC_IN_W + ID_W;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  // Grant encoding doubles as the two low bits of req_src_o: bit0 = EN, bit1 = WS.
  typedef enum logic [1:0] {
    GRANT_NONE  = 2'b00,
    GRANT_EN    = 2'b01,
    GRANT_WS    = 2'b10,
    GRANT_MERGE = 2'b11
  } grant_e;

  if (FIFO_DEPTH == 0) begin : g_depth_check
    $fatal(1, "fractal_sync_rx: FIFO_DEPTH must be greater than zero");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  logic [1:0]         sync_in_s;
  logic [ENTRY_W-1:0] data_in_s [2];
  logic [1:0]         push_s;
  logic [ENTRY_W-1:0] push_data_s [2];
  logic [1:0]         empty_s;
  logic [1:0]         full_s;
  logic [1:0]         overflow_s;
  logic [1:0]         pop_s;
  logic [ENTRY_W-1:0] head_s [2];
  logic [ENTRY_W-1:0] sel_s;
  logic [1:0]         grant_free_s;
  logic [1:0]         grant_s;
  logic               valid_s;
  logic               handshake_s;
  grant_e             lock_r;
  logic               rr_q;

  assign sync_in_s    = {ws_sync_i, en_sync_i};
  assign data_in_s[0] = {en_src_i, en_id_i};
  assign data_in_s[1] = {ws_src_i, ws_id_i};

  if (COMB_IN) begin : g_comb_in
    assign push_s      = sync_in_s;
    assign push_data_s = data_in_s;
  end else begin : g_reg_in
    logic [1:0]         sync_r;
    logic [ENTRY_W-1:0] data_r [2];

    // Input staging: strobe always registered, payload captured only with a strobe
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync_r    <= 2'b00;
        data_r[0] <= '0;
        data_r[1] <= '0;
      end else begin
        sync_r <= sync_in_s;
        for (int p = 0; p < 2; p++) begin
          if (sync_in_s[p]) data_r[p] <= data_in_s[p];
        end
      end
    end

    assign push_s      = sync_r;
    assign push_data_s = data_r;
  end

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_r;
    logic [PTR_W-1:0]   rptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign empty_s[p]    = (cnt_r == '0);
    assign full_s[p]     = (cnt_r == CNT_W'(FIFO_DEPTH));
    assign head_s[p]     = mem_r[rptr_r];
    assign do_push_s     = push_s[p] & ~full_s[p];
    assign do_pop_s      = pop_s[p] & ~empty_s[p];
    // A push into a full FIFO is dropped even if the same cycle pops it.
    assign overflow_s[p] = push_s[p] & full_s[p] & ~rst_i;

    // Storage array: written on accepted pushes only
    always_ff @(posedge clk_i) begin
      if (do_push_s) mem_r[wptr_r] <= push_data_s[p];
    end

    // Pointers and occupancy, judged on pre-edge occupancy
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wptr_r <= '0;
        rptr_r <= '0;
        cnt_r  <= '0;
      end else begin
        if (do_push_s) wptr_r <= ptr_inc(wptr_r);
        if (do_pop_s)  rptr_r <= ptr_inc(rptr_r);
        case ({do_push_s, do_pop_s})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  // Free-running arbitration: merge equal heads, otherwise round-robin on contention
  always_comb begin
    grant_free_s = GRANT_NONE;
    if (!empty_s[0] && !empty_s[1]) begin
      if (head_s[0] == head_s[1]) grant_free_s = GRANT_MERGE;
      else if (rr_q)              grant_free_s = GRANT_WS;
      else                        grant_free_s = GRANT_EN;
    end else if (!empty_s[0]) begin
      grant_free_s = GRANT_EN;
    end else if (!empty_s[1]) begin
      grant_free_s = GRANT_WS;
    end else begin
      grant_free_s = GRANT_NONE;
    end
  end

  assign grant_s     = (lock_r != GRANT_NONE) ? lock_r : grant_free_s;
  assign valid_s     = |(grant_s & ~empty_s);
  assign req_valid_o = valid_s & ~rst_i;
  assign handshake_s = req_valid_o & req_ready_i;
  assign pop_s       = {2{handshake_s}} & grant_s;
  assign sel_s       = grant_s[0] ? head_s[0] : head_s[1];

  assign en_error_overflow_o = overflow_s[0];
  assign ws_error_overflow_o = overflow_s[1];

  // Output payload, forced to zero whenever no request is offered
  always_comb begin
    req_src_o = '0;
    req_id_o  = '0;
    if (req_valid_o) begin
      req_src_o = {sel_s[ENTRY_W-1:ID_W], grant_s};
      req_id_o  = sel_s[ID_W-1:0];
    end else begin
      req_src_o = '0;
      req_id_o  = '0;
    end
  end

  // Grant-lock FSM and round-robin pointer: a stalled offer freezes its grant type
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_r <= GRANT_NONE;
      rr_q   <= 1'b0;
    end else if (handshake_s) begin
      lock_r <= GRANT_NONE;
      if (grant_s == GRANT_EN)      rr_q <= 1'b1;
      else if (grant_s == GRANT_WS) rr_q <= 1'b0;
      else                          rr_q <= rr_q;
    end else if (req_valid_o) begin
      lock_r <= grant_e'(grant_s);
      rr_q   <= rr_q;
    end else begin
      lock_r <= GRANT_NONE;
      rr_q   <= rr_q;
    end
  end

endmodule
